vector_store_unit: RTL and testbench
====================================

# vector_store_unit

- Memory-side writer for the vector datapath.
- Accepts one vector store request (base address, `vecSize` lanes of `registerSize` bits, lane mask) from the execute/memory pipeline.
- Serializes the request into single-lane writes on a one-element-wide data memory write port, one lane per cycle.
- While busy it holds off new requests and signals a stall; it is the write-side counterpart of the writeback stage's vector read path.

## Interface
- `vecSize`, default 4: lanes per vector; must be ≥ 1.
- `registerSize`, default 8: bits per lane; also the memory address width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_address`  in  registerSize  base address of lane 0.
- `req_data`  in  [vecSize-1:0][registerSize-1:0]  vector to store; lane i is `req_data[i]`.
- `req_mask`  in  vecSize  per-lane write enable; bit i = lane i.
- `mem_we`  out  1  memory write strobe for the current lane.
- `mem_address`  out  registerSize  memory address for the current lane.
- `mem_wdata`  out  registerSize  memory data for the current lane.
- `busy`  out  1  high in WRITE and DONE; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse after the last lane slot.

## Operation
- Handshake: a request is accepted on a rising edge where `req_valid && req_ready`.
  - On acceptance, capture `req_address`, `req_data` and `req_mask` into internal registers.
  - Inputs are ignored at all other times.
- FSM states are IDLE, WRITE and DONE.
  - IDLE: `req_ready=1`, `busy=0`. On accept, clear lane index `idx` to 0 and go to WRITE.
  - WRITE: `req_ready=0`, `busy=1`.
    - Drive `mem_address = base + idx`, truncated to `registerSize` bits (wraps modulo 2^registerSize).
    - Drive `mem_wdata = data[idx]` and `mem_we = mask[idx]`.
    - If `idx == vecSize-1`, go to DONE; otherwise increment `idx`.
  - DONE: `done=1`, `busy=1`, `req_ready=0`, `mem_we=0`. Unconditionally go to IDLE.
- Outputs decode from registered state, `idx` and captured data. No combinational path from `req_*` to `mem_*`.
- In IDLE and DONE, `mem_address` and `mem_wdata` are 0.
- Masked-off lanes still consume their cycle; latency is fixed and independent of the mask.
- An all-zero mask gives `vecSize` WRITE cycles with `mem_we=0`, then a normal `done`.
- `req_valid` held high in DONE has no effect; it is accepted once the unit is back in IDLE.

## Timing
- Reset (synchronous) forces the values below. This applies mid-operation too: remaining lanes are dropped and no `done` is issued.
  - State IDLE, `idx=0`, captured registers 0.
  - Outputs: `req_ready=1`, `mem_we=0`, `mem_address=0`, `mem_wdata=0`, `busy=0`, `done=0`.
- Request accepted at edge T:
  - Lane 0 is presented during cycle T+1 and lane i during T+1+i.
  - The last lane is presented during T+vecSize.
  - `done` is high during T+vecSize+1.
  - `req_ready` is high again during T+vecSize+2.
- Back-to-back requests: throughput is one request per vecSize+2 cycles.
- The memory samples `mem_we`/`mem_address`/`mem_wdata` on the rising edge that ends each WRITE cycle.

## Configuration
- Macro `VSU_LANE_MASK_EN`.
- Defined: `req_mask` is captured and gates `mem_we` per lane as described above.
- Undefined: the mask register is not built and `req_mask` is ignored. `mem_we=1` in every WRITE cycle. Timing is identical.

## Test plan
- Basic store: defaults, `req_address=0x10`, data lanes {0xA0,0xA1,0xA2,0xA3}, mask 4'b1111 → writes 0x10←0xA0, 0x11←0xA1, 0x12←0xA2, 0x13←0xA3 on consecutive cycles; `done` at T+5; `req_ready` at T+6.
- Mask: same request with mask 4'b0101 and `VSU_LANE_MASK_EN` defined → `mem_we` high only for lanes 0 and 2. Same latency; mask 4'b0000 gives no writes but `done` still at T+5.
- Wrap-around: `req_address=0xFE` → addresses 0xFE, 0xFF, 0x00, 0x01.
- Back-pressure: hold `req_valid=1` with two distinct requests → second accepted only at T+6; `req_ready=0` and `busy=1` from T+1 through T+5.
- Reset mid-operation: assert `reset` during the lane-1 cycle → next cycle all outputs at reset values, no `done`, lanes 2 and 3 never written; a new request is accepted immediately after.
- Macro off: undefined `VSU_LANE_MASK_EN`, mask 4'b0000 → all four lanes written.

Source files
------------

// File: rtl/vector_store_unit.sv
// vector_store_unit: serializes one captured vector store into single-lane
// memory writes, one lane per cycle, with a trailing done pulse.
// Optional feature macro: VSU_LANE_MASK_EN (per-lane write enable from req_mask).
//
// state | meaning
// IDLE  | ready for a request, memory port quiet
// WRITE | presenting lane idx on the memory port
// DONE  | one-cycle completion pulse, memory port quiet
module vector_store_unit #(
  parameter int vecSize      = 4,
  parameter int registerSize = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [registerSize-1:0]                req_address,
  input  logic [vecSize-1:0][registerSize-1:0]   req_data,
  input  logic [vecSize-1:0]                     req_mask,
  output logic                                   mem_we,
  output logic [registerSize-1:0]                mem_address,
  output logic [registerSize-1:0]                mem_wdata,
  output logic                                   busy,
  output logic                                   done
);

  localparam int IDX_W = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(vecSize - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} stateT;

  stateT                                state;
  stateT                                nextState;
  logic [IDX_W-1:0]                     idx;
  logic [registerSize-1:0]              baseReg;
  logic [vecSize-1:0][registerSize-1:0] dataReg;
  logic                                 accept;
  logic                                 laneWe;

  assign accept = req_valid && (state == IDLE);

`ifdef VSU_LANE_MASK_EN
  logic [vecSize-1:0] maskReg;

  // Capture the lane mask alongside the request.
  always_ff @(posedge clk) begin
    if (reset)       maskReg <= '0;
    else if (accept) maskReg <= req_mask;
  end

  assign laneWe = maskReg[idx];
`else
  logic unusedMask;
  assign unusedMask = ^req_mask;
  assign laneWe     = 1'b1;
`endif

  // State register, lane index and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      baseReg <= '0;
      dataReg <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        idx     <= '0;
        baseReg <= req_address;
        dataReg <= req_data;
      end else if (state == WRITE && idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Next-state and output decode from registered state only.
  always_comb begin
    nextState   = state;
    req_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nextState = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        mem_we      = laneWe;
        mem_address = baseReg + registerSize'(idx);
        mem_wdata   = dataReg[idx];
        if (idx == LAST_IDX) nextState = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_store_unit.sv
// Bench for vector_store_unit: cycle-level reference model driven by the
// accept time of each request, plus a small write-capture memory.
module tb_vector_store_unit;
  localparam int V = 4;
  localparam int R = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             reqValid;
  logic             reqReady;
  logic [R-1:0]     reqAddress;
  logic [V-1:0][R-1:0] reqData;
  logic [V-1:0]     reqMask;
  logic             memWe;
  logic [R-1:0]     memAddress;
  logic [R-1:0]     memWdata;
  logic             busy;
  logic             done;

  vector_store_unit #(.vecSize(V), .registerSize(R)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_address(reqAddress), .req_data(reqData), .req_mask(reqMask),
    .mem_we(memWe), .mem_address(memAddress), .mem_wdata(memWdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model state: the accepted request and the cycle it was accepted in.
  int            cyc = 0;
  bit            started = 0;
  bit            mActive = 0;
  int            mT = 0;
  logic [R-1:0]  mBase;
  logic [V-1:0][R-1:0] mData;
  logic [V-1:0]  mMask;
  int            acceptCnt = 0;
  int            lastAcceptCyc = 0;
  int            doneCyc = -1;
  logic [R-1:0]  memArr [256];
  bit            written [256];

  // Model update and write capture on every rising edge.
  always @(posedge clk) begin
    started = 1;
    if (memWe) begin
      memArr[memAddress]  = memWdata;
      written[memAddress] = 1;
    end
    if (done) doneCyc = cyc;
    if (reset) begin
      mActive = 0;
    end else if (reqValid && (!mActive || (cyc - mT) >= V + 2)) begin
      mActive       = 1;
      mT            = cyc;
      mBase         = reqAddress;
      mData         = reqData;
      mMask         = reqMask;
      acceptCnt++;
      lastAcceptCyc = cyc;
    end
    cyc++;
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      int e;
      logic          eReady, eBusy, eDone, eWe;
      logic [R-1:0]  eAddr, eData;
      e      = cyc - mT;
      eReady = 1; eBusy = 0; eDone = 0; eWe = 0; eAddr = '0; eData = '0;
      if (mActive && e >= 1 && e <= V) begin
        eReady = 0; eBusy = 1;
        eAddr  = R'(mBase + R'(e - 1));
        eData  = mData[e-1];
`ifdef VSU_LANE_MASK_EN
        eWe    = mMask[e-1];
`else
        eWe    = 1;
`endif
      end else if (mActive && e == V + 1) begin
        eReady = 0; eBusy = 1; eDone = 1;
      end
      chk("req_ready",   32'(reqReady),   32'(eReady));
      chk("busy",        32'(busy),       32'(eBusy));
      chk("done",        32'(done),       32'(eDone));
      chk("mem_we",      32'(memWe),      32'(eWe));
      chk("mem_address", 32'(memAddress), 32'(eAddr));
      chk("mem_wdata",   32'(memWdata),   32'(eData));
    end
  end

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin
      memArr[i]  = '0;
      written[i] = 0;
    end
  endtask

  // Present a request and hold it until the model reports acceptance.
  task automatic waitAccept(input string name);
    int n;
    n = acceptCnt;
    for (int k = 0; k < 20 && acceptCnt == n; k++) begin
      @(posedge clk); #1;
    end
    chk({name, "_accept_timeout"}, 32'(acceptCnt != n), 32'd1);
  endtask

  task automatic send(input logic [R-1:0] a, input logic [V-1:0][R-1:0] d,
                      input logic [V-1:0] m, input string name);
    reqAddress = a; reqData = d; reqMask = m; reqValid = 1;
    waitAccept(name);
    reqValid = 0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int t1;
    reset = 1; reqValid = 0; reqAddress = '0; reqData = '0; reqMask = '0;
    clearMem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(reqReady), 32'd1);
    chk("reset_busy",  32'(busy),     32'd0);
    reset = 0;
    @(posedge clk); #1;

    // Basic store
    clearMem();
    send(8'h10, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 4'b1111, "basic");
    t1 = lastAcceptCyc;
    settle();
    chk("basic_done_lat", 32'(doneCyc - t1), 32'd5);
    chk("basic_m10", 32'(memArr[8'h10]), 32'hA0);
    chk("basic_m11", 32'(memArr[8'h11]), 32'hA1);
    chk("basic_m12", 32'(memArr[8'h12]), 32'hA2);
    chk("basic_m13", 32'(memArr[8'h13]), 32'hA3);

    // Partial mask
    clearMem();
    send(8'h10, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 4'b0101, "mask");
    t1 = lastAcceptCyc;
    settle();
    chk("mask_done_lat", 32'(doneCyc - t1), 32'd5);
    chk("mask_w10", 32'(written[8'h10]), 32'd1);
    chk("mask_w12", 32'(written[8'h12]), 32'd1);
`ifdef VSU_LANE_MASK_EN
    chk("mask_w11", 32'(written[8'h11]), 32'd0);
    chk("mask_w13", 32'(written[8'h13]), 32'd0);
`else
    chk("mask_w11", 32'(written[8'h11]), 32'd1);
    chk("mask_w13", 32'(written[8'h13]), 32'd1);
`endif

    // All-zero mask
    clearMem();
    send(8'h20, {8'hB3, 8'hB2, 8'hB1, 8'hB0}, 4'b0000, "zmask");
    t1 = lastAcceptCyc;
    settle();
    chk("zmask_done_lat", 32'(doneCyc - t1), 32'd5);
`ifdef VSU_LANE_MASK_EN
    chk("zmask_w20", 32'(written[8'h20]), 32'd0);
    chk("zmask_w23", 32'(written[8'h23]), 32'd0);
`else
    chk("zmask_w20", 32'(written[8'h20]), 32'd1);
    chk("zmask_m23", 32'(memArr[8'h23]), 32'hB3);
`endif

    // Address wrap
    clearMem();
    send(8'hFE, {8'hC3, 8'hC2, 8'hC1, 8'hC0}, 4'b1111, "wrap");
    settle();
    chk("wrap_mFE", 32'(memArr[8'hFE]), 32'hC0);
    chk("wrap_mFF", 32'(memArr[8'hFF]), 32'hC1);
    chk("wrap_m00", 32'(memArr[8'h00]), 32'hC2);
    chk("wrap_m01", 32'(memArr[8'h01]), 32'hC3);

    // Back-pressure: valid held across two distinct requests
    clearMem();
    reqAddress = 8'h30; reqData = {8'hD3, 8'hD2, 8'hD1, 8'hD0}; reqMask = 4'b1111; reqValid = 1;
    waitAccept("bp1");
    t1 = lastAcceptCyc;
    reqAddress = 8'h50; reqData = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
    waitAccept("bp2");
    reqValid = 0;
    chk("bp_spacing", 32'(lastAcceptCyc - t1), 32'd6);
    settle();
    chk("bp_m33", 32'(memArr[8'h33]), 32'hD3);
    chk("bp_m50", 32'(memArr[8'h50]), 32'hE0);

    // Reset during the lane-1 cycle, new request waiting behind it
    clearMem();
    send(8'h40, {8'hF3, 8'hF2, 8'hF1, 8'hF0}, 4'b1111, "rst1");
    t1 = lastAcceptCyc;
    @(posedge clk); #1;
    reset = 1;
    reqAddress = 8'h60; reqData = {8'h93, 8'h92, 8'h91, 8'h90}; reqMask = 4'b1111; reqValid = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_ready", 32'(reqReady), 32'd1);
    chk("rst_we",    32'(memWe),    32'd0);
    waitAccept("rst2");
    reqValid = 0;
    chk("rst_reaccept", 32'(lastAcceptCyc - t1), 32'd3);
    settle();
    chk("rst_w40", 32'(written[8'h40]), 32'd1);
    chk("rst_w41", 32'(written[8'h41]), 32'd1);
    chk("rst_w42", 32'(written[8'h42]), 32'd0);
    chk("rst_w43", 32'(written[8'h43]), 32'd0);
    chk("rst_m63", 32'(memArr[8'h63]), 32'h93);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
